// File: rtl/uart_fifo_param.sv
// First-word-fall-through FIFO for the UART TX/RX paths, with configurable width and depth.
// Provides a fill level, almost-full/almost-empty flags, sticky error flags and a flush.
module uart_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              write_en,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int          LVL_W = ADDR_W + 1;

    localparam logic [ADDR_W:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [ADDR_W:0] LVL_AF   = LVL_W'(AF_THRESH);
    localparam logic [ADDR_W:0] LVL_AE   = LVL_W'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic              overflow_q;
    logic              underflow_q;

    logic push_ok;
    logic pop_ok;
    logic do_push;
    logic do_pop;
    logic ovf_evt;
    logic unf_evt;

    always_comb begin
        empty        = (level_q == '0);
        full         = (level_q == LVL_FULL);
        almost_empty = (level_q <= LVL_AE);
        almost_full  = (level_q >= LVL_AF);
        level        = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        read_data    = empty ? '0 : mem[rd_ptr];
    end

    // A read on a full FIFO frees a slot in the same cycle, so the write is kept.
    always_comb begin
        push_ok = write_en & (~full | read_en);
        pop_ok  = read_en & ~empty;
        do_push = push_ok & ~flush;
        do_pop  = pop_ok & ~flush;
        ovf_evt = write_en & ~push_ok & ~flush;
        unf_evt = read_en & empty & ~flush;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A new error event in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (unf_evt) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench for uart_fifo_param: a queue scoreboard predicts read data,
// and a small model predicts level, flags and the sticky error bits.
module tb_uart_fifo_param;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;
    logic [7:0] read_data;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [7:0] sb[$];
    logic       exp_ovf;
    logic       exp_unf;

    uart_fifo_param #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .AF_THRESH(12),
        .AE_THRESH(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_en     (read_en),
        .read_data   (read_data),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int cnt;
        cnt = sb.size();
        check({tag, ".level"}, 32'(level), 32'(cnt));
        check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, ".full"}, 32'(full), 32'(cnt == DEPTH));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 2));
        check({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 12));
        check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
        check({tag, ".rdata"}, 32'(read_data), (cnt == 0) ? 32'h0 : 32'(sb[0]));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".level"}, 32'(level), 32'h0);
        check({tag, ".empty"}, 32'(empty), 32'h1);
        check({tag, ".aempty"}, 32'(almost_empty), 32'h1);
        check({tag, ".full"}, 32'(full), 32'h0);
        check({tag, ".afull"}, 32'(almost_full), 32'h0);
        check({tag, ".rdata"}, 32'(read_data), 32'h0);
        check({tag, ".ovf"}, 32'(overflow), 32'h0);
        check({tag, ".unf"}, 32'(underflow), 32'h0);
    endtask

    // Entered on a falling edge; drives one cycle of stimulus and checks after the rising edge.
    task automatic step(input string tag, input logic we, input logic [7:0] wd,
                        input logic re, input logic fl, input logic ec);
        int  cnt;
        logic ovf_evt;
        logic unf_evt;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        flush      = fl;
        err_clr    = ec;
        cnt     = sb.size();
        ovf_evt = we && cnt == DEPTH && !re && !fl;
        unf_evt = re && cnt == 0 && !fl;
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (re && cnt > 0) begin
                check({tag, ".pop"}, 32'(read_data), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (we && (cnt < DEPTH || re)) begin
                sb.push_back(wd);
            end
        end
        if (ovf_evt) exp_ovf = 1'b1;
        else if (ec) exp_ovf = 1'b0;
        if (unf_evt) exp_unf = 1'b1;
        else if (ec) exp_unf = 1'b0;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        check_state(tag);
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
        reset_n    = 1'b0;
        flush      = 1'b0;
        write_en   = 1'b0;
        write_data = 8'h00;
        read_en    = 1'b0;
        err_clr    = 1'b0;

        #3;
        check_reset("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step("ovf_wr", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'h1);
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("drained_empty", 32'(empty), 32'h1);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) step("wrap_pre", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step("wrap_wr", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) step("full2", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step("full_rw", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("full_rw_noovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 15; i++) step("full_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("last_is_55", 32'(read_data), 32'h55);
        step("full_last", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Simultaneous read and write while empty, then sticky-flag clear behaviour.
        step("empty_rw", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("empty_rw_unf", 32'(underflow), 32'h1);
        check("empty_rw_data", 32'(read_data), 32'h77);
        step("unf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step("pop77", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step("unf_setwins", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("setwins_unf", 32'(underflow), 32'h1);
        step("unf_clr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush has priority over a same-cycle write.
        for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step("flush_wr", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        check("flush_level", 32'(level), 32'h0);

        // Asynchronous reset mid-burst, checked between clock edges.
        for (int i = 0; i < 3; i++) step("burst", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step("burst_ovf", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        write_en   = 1'b1;
        write_data = 8'hC3;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("async_rst");
        write_en = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        step("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
